// File: rtl/demux32_loader.sv
// Word-serial to 32-lane loader: word k of a block lands in lane k; the full bank
// is offered on out_data once 32 words are in. Optional DEMUX32_LOADER_BSWAP_EN byte-reverses words.
module demux32_loader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*DATA_WIDTH-1:0] out_data,
  output logic [4:0]               idx,
  output logic                     err
);

  typedef enum logic {FILL, FULL} state_e;

  state_e                          state_q, state_d;
  logic [4:0]                      idx_q, idx_d;
  logic                            err_q, err_d;
  logic                            accept;
  logic [DATA_WIDTH-1:0]           wdata;
  logic [31:0][DATA_WIDTH-1:0]     bank_q;

`ifdef DEMUX32_LOADER_BSWAP_EN
  localparam int NB = DATA_WIDTH / 8;
  for (genvar b = 0; b < NB; b++) begin : g_bswap
    assign wdata[b*8 +: 8] = in_data[(NB-1-b)*8 +: 8];
  end
`else
  assign wdata = in_data;
`endif

  // Handshake outputs come from the state register only.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid && in_ready && !flush;
  assign idx       = idx_q;
  assign err       = err_q;
  assign out_data  = bank_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (flush) begin
      state_d = FILL;
      idx_d   = '0;
    end else begin
      case (state_q)
        FILL: if (accept) begin
          if (in_last != (idx_q == 5'd31)) err_d = 1'b1;
          if (idx_q == 5'd31) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        FULL: if (out_ready) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Lanes are never cleared between blocks; the next block overwrites them.
  for (genvar k = 0; k < 32; k++) begin : g_lane
    always_ff @(posedge clk) begin
      if (!rst_n)                          bank_q[k] <= '0;
      else if (accept && idx_q == 5'(k))   bank_q[k] <= wdata;
    end
  end

endmodule

// File: tb/tb_demux32_loader.sv
// Randomized bench for demux32_loader against a block-level scoreboard model.
module tb_demux32_loader;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_last, out_ready;
  logic        in_ready, out_valid, err;
  logic [31:0] in_data;
  logic [1023:0] out_data;
  logic [4:0]  idx;

  int n_cmp = 0;
  int n_bad = 0;

  // model: words collected so far in the open block, a pending-block flag, lanes, sticky error
  logic [31:0] m_lane [32];
  int          m_cnt;
  bit          m_pend;
  bit          m_err;

  always #5 clk = ~clk;

  demux32_loader #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .idx(idx), .err(err)
  );

  function automatic logic [31:0] stored(input logic [31:0] d);
`ifdef DEMUX32_LOADER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_of(input int k);
    return out_data[k*32 +: 32];
  endfunction

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic cyc(input bit rn, input bit fl, input bit v, input logic [31:0] d,
                     input bit last, input bit ordy);
    rst_n = rn; flush = fl; in_valid = v; in_data = d; in_last = last; out_ready = ordy;
    if (!rn) begin
      m_pend = 0; m_cnt = 0; m_err = 0;
      for (int k = 0; k < 32; k++) m_lane[k] = '0;
    end else if (fl) begin
      m_pend = 0; m_cnt = 0;
    end else if (!m_pend) begin
      if (v) begin
        m_lane[m_cnt] = stored(d);
        if (last != (m_cnt == 31)) m_err = 1;
        m_cnt++;
        if (m_cnt == 32) begin m_cnt = 0; m_pend = 1; end
      end
    end else if (ordy) begin
      m_pend = 0;
    end
    @(posedge clk);
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_pend));
    chk("out_valid", 32'(out_valid), 32'(m_pend));
    chk("idx", 32'(idx), 32'(m_cnt));
    chk("err", 32'(err), 32'(m_err));
    for (int k = 0; k < 32; k++) chk($sformatf("lane%0d", k), lane_of(k), m_lane[k]);
  endtask

  task automatic word(input int k, input logic [31:0] d);
    cyc(1, 0, 1, d, k == 31, 0);
  endtask

  task automatic drain();
    cyc(1, 0, 0, 32'h0, 0, 1);
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
    m_cnt = 0; m_pend = 0; m_err = 0;
    for (int k = 0; k < 32; k++) m_lane[k] = '0;
    cyc(0, 1, 1, 32'hDEAD_BEEF, 0, 1);
    cyc(0, 0, 0, 32'h0, 0, 0);
    chk("rst_out_data0", lane_of(0), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Clean block A000_0000+k
    for (int k = 0; k < 32; k++) word(k, 32'hA000_0000 + k);
    chk("blk_out_valid", 32'(out_valid), 32'd1);
    chk("blk_err", 32'(err), 32'd0);
    chk("blk_idx", 32'(idx), 32'd0);
    chk("blk_lane5", lane_of(5), stored(32'hA000_0005));
    chk("blk_lane31", lane_of(31), stored(32'hA000_001F));

    // Backpressure with in_valid high
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 32'h5555_0000 + i, 0, 0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_lane0", lane_of(0), stored(32'hA000_0000));
    cyc(1, 0, 1, 32'h6666_6666, 0, 1);
    chk("bp_release", 32'(in_ready), 32'd1);
    cyc(1, 0, 1, 32'h1122_3344, 0, 0);
    chk("lane0_store", lane_of(0), stored(32'h1122_3344));
`ifdef DEMUX32_LOADER_BSWAP_EN
    chk("bswap_lane0", lane_of(0), 32'h4433_2211);
`else
    chk("plain_lane0", lane_of(0), 32'h1122_3344);
`endif
    for (int k = 1; k < 32; k++) word(k, $urandom);
    drain();

    // Flush alongside the 8th word
    for (int k = 0; k < 7; k++) word(k, $urandom);
    cyc(1, 1, 1, 32'hBAD0_0008, 0, 0);
    chk("flush_idx", 32'(idx), 32'd0);
    for (int k = 0; k < 32; k++) word(k, 32'hC000_0000 + k);
    chk("flush_lane7", lane_of(7), stored(32'hC000_0007));
    drain();
    chk("flush_err", 32'(err), 32'd0);

    // Framing: early in_last, block still completes
    for (int k = 0; k < 32; k++) begin
      cyc(1, 0, 1, $urandom, k == 5, 0);
      if (k == 5) chk("early_last_err", 32'(err), 32'd1);
    end
    chk("early_last_done", 32'(out_valid), 32'd1);
    drain();
    cyc(0, 0, 0, 32'h0, 0, 0);
    chk("rst_clears_err", 32'(err), 32'd0);
    for (int k = 0; k < 32; k++) cyc(1, 0, 1, $urandom, 0, 0);
    chk("missing_last_err", 32'(err), 32'd1);
    drain();
    cyc(0, 0, 0, 32'h0, 0, 0);

    // Random gaps and backpressure across several blocks, occasional flush
    for (int i = 0; i < 300; i++) begin
      int w;
      w = m_cnt;
      cyc(1, ($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom,
          (w == 31), $urandom_range(0, 1));
    end
    for (int i = 0; i < 3; i++) drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux32_loader.md
# demux32_loader

Word-serial to 32-lane loader: accepts a stream of DATA_WIDTH-bit words over a valid/ready handshake and steers word k into lane k of a 32-word register bank. When all 32 lanes are filled, it presents the whole bank as one block on a valid/ready output. It is the write-side counterpart of the 32:1 word selector: it builds the 1024-bit (32 × 32) block that the selector later reads lane by lane with sel = k.

## Interface

Parameters
- DATA_WIDTH, 32, width of one word/lane.

Ports
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous abort of the current block.
- in_valid  in  1  in_data holds a word.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  DATA_WIDTH  word to be stored at the current lane index.
- in_last  in  1  marks the 32nd word of a block.
- out_valid  out  1  out_data holds a complete block.
- out_ready  in  1  consumer takes the block.
- out_data  out  32*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- idx  out  5  next lane to be written (0..31).
- err  out  1  sticky framing error.

## Operation

- State machine with two states:
  - FILL: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - lane[idx] ← in_data (see Configuration).
  - If idx==31: idx ← 0 and state ← FULL.
  - Otherwise: idx ← idx+1.
  - idx is a 5-bit counter that wraps 31→0 only through this rule.
- FULL:
  - Holds the bank and out_data stable while out_valid && !out_ready.
  - On out_ready: state ← FILL.
  - The bank is not cleared; stale lanes are overwritten by the next block.
- Framing check (on accept only): err ← 1 if in_last=1 with idx≠31, or in_last=0 with idx==31.
  - The block still completes on the 32nd word regardless of in_last; idx alone decides completion.
  - err is cleared only by reset.
- flush=1: state ← FILL, idx ← 0. Lanes and err are unchanged.
  - Flush has priority over a simultaneous accept (the word is dropped) and over a simultaneous out_ready.
- Reset (rst_n=0, synchronous): state=FILL, idx=0, err=0, all lanes 0.
  - Reset overrides flush and all handshakes.
  - Reset in the middle of a block discards the partial block.

## Timing

- Reset values: in_ready=1, out_valid=0, out_data=0, idx=0, err=0.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from out_ready or in_valid to in_ready.
- Latency: out_valid rises in the cycle after the 32nd accept, and out_data is valid in that same cycle.
- Throughput: at most 32 words per 33 cycles. The FULL→FILL transition costs one cycle, and in_ready returns 1 in the cycle after the out_ready handshake.
- A word can be accepted every cycle in FILL. Back-to-back accepts write consecutive lanes.
- err updates on the edge of the offending accept and is visible the following cycle.

## Configuration

- DEMUX32_LOADER_BSWAP_EN:
  - Defined: each accepted word is byte-reversed before storage, converting the little-endian words used by the scrypt data path. Requires DATA_WIDTH to be a multiple of 8. For example, in_data 32'h11223344 is stored as 32'h44332211.
  - Undefined: words are stored unmodified.
- Handshake, latency and framing behaviour are identical in both builds.

## Test plan

- Reset, then stream words 0..31 with value 32'hA000_0000+k, in_valid held high and in_last only on word 31:
  - out_valid=1 in cycle 33.
  - out_data lane k = 32'hA000_0000+k.
  - err=0 and idx=0.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid stays high:
  - in_ready=0 throughout and out_data stays stable.
  - After out_ready=1 for one cycle, in_ready=1 the next cycle and the next word lands in lane 0.
- Random in_valid gaps (about 50% duty) across 3 blocks: every lane matches the sent word. No word is lost or duplicated.
- Flush after 7 accepts, asserted in the same cycle as an 8th in_valid:
  - The 8th word is dropped and idx=0 next cycle.
  - The following 32 words form a correct block.
- Framing:
  - in_last on word 5 → err=1 next cycle, and the block still completes after 32 words.
  - A separate run without in_last on word 31 → err=1.
  - Reset clears err.
- With DEMUX32_LOADER_BSWAP_EN defined, word 32'h11223344 into lane 0 → lane 0 reads 32'h44332211. Without the macro, the same run → 32'h11223344.
